// File: rtl/nabp_filtered_line_loader_pkg.sv
// Shared definitions for the NABP filtered-line loader and its neighbours.
// Holds the loader and sinogram addresser state encodings and the default
// sinogram RAM read latency, so that both sides agree on the same values.
package nabp_filtered_line_loader_pkg;

    // Default sinogram RAM read latency in cycles (must be >= 1).
    localparam int kSinogramReadLatencyDefault = 2;

    // Loader states: wait for a kick, issue one line of s indices,
    // let the read pipeline drain, then offer the completed line.
    typedef enum logic [1:0] {
        idle_s  = 2'd0,
        fill_s  = 2'd1,
        drain_s = 2'd2,
        swap_s  = 2'd3
    } loader_state_t;

    // Sinogram addresser states, kept beside the loader encoding because
    // the two machines start together on the same kick.
    typedef enum logic [1:0] {
        hs_idle_s  = 2'd0,
        hs_ready_s = 2'd1,
        hs_fill_s  = 2'd2,
        hs_wait_s  = 2'd3
    } addresser_state_t;

    // Width of a counter that must reach latency-1 without overflowing.
    function automatic int drain_counter_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/nabp_valid_delay.sv
// Fixed-depth valid/data delay line. Used to carry each issued sample index
// alongside the sinogram RAM read so the index and the read data line up.
module nabp_valid_delay #(
    parameter int kDepth = 2,
    parameter int kWidth = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [kWidth-1:0] in_data,
    output logic              out_valid,
    output logic [kWidth-1:0] out_data
);

    logic [kDepth-1:0] valid_q;
    logic [kDepth-1:0] valid_d;
    logic [kWidth-1:0] data_q [kDepth];
    logic [kWidth-1:0] data_d [kDepth];

    // Next-state of the shift line: new entry at stage 0, every stage moves one on.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path
        // (here stage 0 first, then each later stage), otherwise a latch is inferred.
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < kDepth; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    // Valid bits are cleared by reset so no stale entry can emerge afterwards.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every stage samples the
        // pre-edge value of its neighbour; = here would collapse the shift line.
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data stages carry no reset; they are only observed when the matching valid is set.
    always_ff @(posedge clk) begin
        // NOTE: payload storage is deliberately left unreset; the valid bits
        // alone decide whether an entry exists.
        for (int i = 0; i < kDepth; i++) begin
            data_q[i] <= data_d[i];
        end
    end

    assign out_valid = valid_q[kDepth-1];
    assign out_data  = data_q[kDepth-1];

endmodule

// File: rtl/nabp_filtered_line_loader.sv
// Filtered line loader: on a kick, walks s = 0..N-1 through the sinogram
// addresser, writes each returned sample into the current line-buffer bank,
// and then offers the finished line to the processing side until it swaps.
module nabp_filtered_line_loader
    import nabp_filtered_line_loader_pkg::*;
#(
    parameter int kSLength             = 8,
    parameter int kAngleLength         = 8,
    parameter int kFilteredDataLength  = 16,
    parameter int kProjectionLineSize  = 256,
    parameter int kSinogramReadLatency = kSinogramReadLatencyDefault
) (
    input  logic                           clk,
    input  logic                           reset,
    // control
    input  logic                           ld_kick,
    output logic                           ld_busy,
    output logic                           ld_done,
    // sinogram addresser
    input  logic [kAngleLength-1:0]        fr_angle,
    input  logic                           fr_has_next_angle,
    input  logic                           fr_next_angle_ack,
    output logic [kSLength-1:0]            fr_s_val,
    output logic                           fr_next_angle,
    // sinogram RAM read data
    input  logic [kFilteredDataLength-1:0] sg_data,
    // line-buffer write side
    output logic                           lb_we,
    output logic [kSLength-1:0]            lb_waddr,
    output logic [kFilteredDataLength-1:0] lb_wdata,
    output logic                           lb_wr_bank,
    // line-buffer handshake with the processing side
    output logic                           lb_line_valid,
    output logic [kAngleLength-1:0]        lb_angle,
    input  logic                           lb_swap
);

    localparam int                    kDrainWidth = drain_counter_width(kSinogramReadLatency);
    localparam logic [kSLength-1:0]    kLastS      = kSLength'(kProjectionLineSize - 1);
    localparam logic [kDrainWidth-1:0] kLastDrain  = kDrainWidth'(kSinogramReadLatency - 1);

    loader_state_t          state_q, state_d;
    logic [kSLength-1:0]    s_val_q, s_val_d;
    logic [kDrainWidth-1:0] drain_cnt_q, drain_cnt_d;
    logic                   wr_bank_q, wr_bank_d;

    // The processing side takes the line only while it is actually on offer.
    logic swap_take;
    assign swap_take = (state_q == swap_s) && lb_swap;

    // Next-state logic: sequencing of fill, drain and swap plus the s counter.
    always_comb begin
        state_d     = state_q;
        s_val_d     = s_val_q;
        drain_cnt_d = drain_cnt_q;
        wr_bank_d   = wr_bank_q;
        unique case (state_q)
            idle_s: begin
                if (ld_kick) begin
                    state_d = fill_s;
                    s_val_d = '0;
                end
            end
            fill_s: begin
                // Exact compare at N-1: the counter never runs past the line end.
                if (s_val_q == kLastS) begin
                    state_d     = drain_s;
                    s_val_d     = '0;
                    drain_cnt_d = '0;
                end else begin
                    s_val_d = s_val_q + 1'b1;
                end
            end
            drain_s: begin
                // The last issued index needs L cycles to reach the buffer.
                if (drain_cnt_q == kLastDrain) begin
                    state_d     = swap_s;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            swap_s: begin
                if (lb_swap) begin
                    wr_bank_d = ~wr_bank_q;
                    s_val_d   = '0;
                    state_d   = fr_next_angle_ack ? fill_s : idle_s;
                end
            end
            default: begin
                state_d = idle_s;
            end
        endcase
    end

    // State registers with synchronous reset back to an idle, bank-0 loader.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= idle_s;
            s_val_q     <= '0;
            drain_cnt_q <= '0;
            wr_bank_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_val_q     <= s_val_d;
            drain_cnt_q <= drain_cnt_d;
            wr_bank_q   <= wr_bank_d;
        end
    end

    // Read-latency alignment: every s issued during fill re-emerges L cycles
    // later, exactly when its sinogram sample is on sg_data.
    logic                issue_valid;
    logic                pipe_valid;
    logic [kSLength-1:0] pipe_s;

    assign issue_valid = (state_q == fill_s);

    nabp_valid_delay #(
        .kDepth (kSinogramReadLatency),
        .kWidth (kSLength)
    ) u_valid_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue_valid),
        .in_data   (s_val_q),
        .out_valid (pipe_valid),
        .out_data  (pipe_s)
    );

    // Outputs. A write still in flight is suppressed as soon as reset is seen,
    // so nothing lands in the line buffer once reset has been raised.
    assign fr_s_val      = s_val_q;
    assign ld_busy       = (state_q != idle_s);
    assign lb_we         = pipe_valid && !reset;
    assign lb_waddr      = pipe_s;
    assign lb_wdata      = sg_data;
    assign lb_wr_bank    = wr_bank_q;
    assign lb_line_valid = (state_q == swap_s);
    assign lb_angle      = (state_q == swap_s) ? fr_angle : '0;
    assign fr_next_angle = swap_take;
    assign ld_done       = swap_take && !fr_has_next_angle;

endmodule

// File: tb/tb_nabp_filtered_line_loader.sv
// Scoreboard bench for nabp_filtered_line_loader (N=256, L=2).
// The bench models the sinogram RAM, predicts every line-buffer write
// (cycle, address, data, bank) from the line rules, and a monitor process
// consumes those predictions whenever the DUT writes.
module tb_nabp_filtered_line_loader;

    localparam int N = 256;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_kick;
    logic        ld_busy;
    logic        ld_done;
    logic [7:0]  fr_angle;
    logic        fr_has_next_angle;
    logic        fr_next_angle_ack;
    logic [7:0]  fr_s_val;
    logic        fr_next_angle;
    logic [15:0] sg_data;
    logic        lb_we;
    logic [7:0]  lb_waddr;
    logic [15:0] lb_wdata;
    logic        lb_wr_bank;
    logic        lb_line_valid;
    logic [7:0]  lb_angle;
    logic        lb_swap;

    nabp_filtered_line_loader dut (
        .clk               (clk),
        .reset             (reset),
        .ld_kick           (ld_kick),
        .ld_busy           (ld_busy),
        .ld_done           (ld_done),
        .fr_angle          (fr_angle),
        .fr_has_next_angle (fr_has_next_angle),
        .fr_next_angle_ack (fr_next_angle_ack),
        .fr_s_val          (fr_s_val),
        .fr_next_angle     (fr_next_angle),
        .sg_data           (sg_data),
        .lb_we             (lb_we),
        .lb_waddr          (lb_waddr),
        .lb_wdata          (lb_wdata),
        .lb_wr_bank        (lb_wr_bank),
        .lb_line_valid     (lb_line_valid),
        .lb_angle          (lb_angle),
        .lb_swap           (lb_swap)
    );

    always #5 clk = ~clk;

    // Cycle index: value seen just after an edge names the cycle that edge started.
    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, gcyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line-buffer write.
    typedef struct {
        int cyc;
        int addr;
        int data;
        bit bank;
    } wr_t;

    wr_t sb[$];

    // Sinogram RAM contents for the line in progress.
    logic [15:0] mem [N];

    task automatic fill_mem(input bit random_fill);
        for (int i = 0; i < N; i++)
            mem[i] = random_fill ? 16'($urandom) : 16'(16'h1000 + i);
    endtask

    // A line whose first fill cycle is f writes address s at cycle f+s+L with mem[s].
    task automatic push_line(input int f, input bit bank);
        for (int s = 0; s < N; s++)
            sb.push_back('{cyc: f + s + L, addr: s, data: int'(mem[s]), bank: bank});
    endtask

    // Sinogram RAM model: data for an address appears L cycles after it is presented.
    int hist [L+1];
    initial begin
        sg_data = '0;
        for (int i = 0; i <= L; i++) hist[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = L; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(fr_s_val);
            sg_data = mem[hist[L]];
        end
    end

    // Monitor: every DUT write must match the oldest outstanding prediction.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #2;
            if (lb_we === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(lb_waddr), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("wr_cycle", 32'(gcyc), 32'(e.cyc));
                    check("wr_addr", 32'(lb_waddr), 32'(e.addr));
                    check("wr_data", 32'(lb_wdata), 32'(e.data));
                    check("wr_bank", 32'(lb_wr_bank), 32'(e.bank));
                end
            end
        end
    end

    // Walk one line from its first fill cycle until the line is on offer.
    // With inject set, a stray kick and swap are raised mid-fill and in drain.
    task automatic do_line(input bit bank, input bit inject);
        for (int s = 0; s < N; s++) begin
            check("fill_s_val", 32'(fr_s_val), 32'(s));
            if (s == 0 || s == N - 1) begin
                check("fill_busy", 32'(ld_busy), 32'd1);
                check("fill_bank", 32'(lb_wr_bank), 32'(bank));
                check("fill_line_valid", 32'(lb_line_valid), 32'd0);
            end
            ld_kick = inject && (s == 50);
            lb_swap = inject && (s == 50);
            if (inject && s == 51) check("ignored_bank", 32'(lb_wr_bank), 32'(bank));
            tick();
        end
        ld_kick = 1'b0;
        lb_swap = 1'b0;
        for (int d = 0; d < L; d++) begin
            check("drain_s_val", 32'(fr_s_val), 32'd0);
            check("drain_line_valid", 32'(lb_line_valid), 32'd0);
            check("drain_next_angle", 32'(fr_next_angle), 32'd0);
            lb_swap = inject && (d == 0);
            tick();
        end
        lb_swap = 1'b0;
        check("line_valid", 32'(lb_line_valid), 32'd1);
        check("swap_bank", 32'(lb_wr_bank), 32'(bank));
        check("swap_busy", 32'(ld_busy), 32'd1);
    endtask

    initial begin
        int  ang;
        bit  found;

        reset = 1'b1;
        ld_kick = 1'b0;
        lb_swap = 1'b0;
        fr_angle = '0;
        fr_has_next_angle = 1'b0;
        fr_next_angle_ack = 1'b0;
        fill_mem(1'b0);
        repeat (3) tick();

        check("rst_busy", 32'(ld_busy), 32'd0);
        check("rst_s_val", 32'(fr_s_val), 32'd0);
        check("rst_we", 32'(lb_we), 32'd0);
        check("rst_line_valid", 32'(lb_line_valid), 32'd0);
        check("rst_bank", 32'(lb_wr_bank), 32'd0);
        check("rst_next_angle", 32'(fr_next_angle), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        reset = 1'b0;
        tick();

        // Line A: angle 0, address pattern data, stray controls injected.
        fr_angle = 8'd0;
        fr_has_next_angle = 1'b1;
        fr_next_angle_ack = 1'b1;
        ld_kick = 1'b1;
        push_line(gcyc + 1, 1'b0);
        tick();
        ld_kick = 1'b0;
        do_line(1'b0, 1'b1);
        check("angle_a", 32'(lb_angle), 32'd0);

        // Processing side holds off for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            check("hold_line_valid", 32'(lb_line_valid), 32'd1);
            check("hold_next_angle", 32'(fr_next_angle), 32'd0);
            check("hold_done", 32'(ld_done), 32'd0);
            tick();
        end

        // Swap with a next angle acknowledged: straight into the next fill.
        fill_mem(1'b1);
        ang = int'($urandom_range(1, 178));
        lb_swap = 1'b1;
        #1;
        check("swap_next_angle", 32'(fr_next_angle), 32'd1);
        check("swap_done_low", 32'(ld_done), 32'd0);
        push_line(gcyc + 1, 1'b1);
        tick();
        lb_swap = 1'b0;
        fr_angle = 8'(ang);
        check("after_swap_next_angle", 32'(fr_next_angle), 32'd0);
        do_line(1'b1, 1'b0);
        check("angle_b", 32'(lb_angle), 32'(ang));
        repeat ($urandom_range(0, 15)) begin
            check("wait_line_valid", 32'(lb_line_valid), 32'd1);
            tick();
        end

        // Final angle: no next angle, loader completes and returns to idle.
        fr_angle = 8'd179;
        fr_has_next_angle = 1'b0;
        fr_next_angle_ack = 1'b0;
        #1;
        check("angle_final", 32'(lb_angle), 32'd179);
        lb_swap = 1'b1;
        #1;
        check("final_next_angle", 32'(fr_next_angle), 32'd1);
        check("final_done", 32'(ld_done), 32'd1);
        tick();
        lb_swap = 1'b0;
        check("final_busy", 32'(ld_busy), 32'd0);
        check("final_done_pulse", 32'(ld_done), 32'd0);
        check("final_bank", 32'(lb_wr_bank), 32'd0);
        check("final_line_valid", 32'(lb_line_valid), 32'd0);

        // A swap request while idle does nothing.
        lb_swap = 1'b1;
        #1;
        check("idle_swap_next_angle", 32'(fr_next_angle), 32'd0);
        tick();
        lb_swap = 1'b0;
        check("idle_swap_bank", 32'(lb_wr_bank), 32'd0);
        check("idle_swap_busy", 32'(ld_busy), 32'd0);

        // Line C: has_next but no ack -> swap goes to idle, bank moves to 1.
        fill_mem(1'b1);
        fr_has_next_angle = 1'b1;
        fr_angle = 8'($urandom);
        ld_kick = 1'b1;
        push_line(gcyc + 1, 1'b0);
        tick();
        ld_kick = 1'b0;
        do_line(1'b0, 1'b0);
        lb_swap = 1'b1;
        #1;
        check("c_next_angle", 32'(fr_next_angle), 32'd1);
        check("c_done", 32'(ld_done), 32'd0);
        tick();
        lb_swap = 1'b0;
        check("c_busy", 32'(ld_busy), 32'd0);
        check("c_bank", 32'(lb_wr_bank), 32'd1);
        check("c_all_written", 32'(sb.size()), 32'd0);

        // Line D: reset while s = 100; pending writes must be discarded.
        fill_mem(1'b1);
        ld_kick = 1'b1;
        push_line(gcyc + 1, 1'b1);
        tick();
        ld_kick = 1'b0;
        found = 1'b0;
        for (int i = 0; i < N && !found; i++) begin
            if (fr_s_val == 8'd100) found = 1'b1;
            else tick();
        end
        check("reached_s100", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 32'(ld_busy), 32'd0);
        check("mid_rst_s_val", 32'(fr_s_val), 32'd0);
        check("mid_rst_bank", 32'(lb_wr_bank), 32'd0);
        check("mid_rst_line_valid", 32'(lb_line_valid), 32'd0);
        check("mid_rst_we", 32'(lb_we), 32'd0);
        // Writes for s = 0..97 landed before reset; the rest never may.
        check("pending_dropped", 32'(sb.size()), 32'(N - 98));
        sb.delete();
        for (int i = 0; i < 30; i++) begin
            check("post_rst_s_val", 32'(fr_s_val), 32'd0);
            check("post_rst_busy", 32'(ld_busy), 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
